// File: rtl/ppdu_framer_if.sv
// ppdu_framer_if: frame request, PSDU byte stream and tagged framed-bit stream of the PPDU framer.
interface ppdu_framer_if #(parameter int LEN_W = 12);
    logic             start;
    logic [3:0]       rate;
    logic [LEN_W-1:0] length;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic [2:0]       field;
    logic             scramble_en;
    logic             code_en;
    logic             seed_load;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, rate, length, byte_in, byte_valid, bit_ready,
        input  byte_ready, bit_out, bit_valid, field, scramble_en, code_en, seed_load, busy, done, error
    );
    modport slave (
        input  start, rate, length, byte_in, byte_valid, bit_ready,
        output byte_ready, bit_out, bit_valid, field, scramble_en, code_en, seed_load, busy, done, error
    );
endinterface

// File: rtl/ppdu_framer.sv
// ppdu_framer: run-time rate/length PPDU bit framer (preamble, SIGNAL, SERVICE, PSDU, tail, pad).
module ppdu_framer #(
    parameter int         PREAMBLE_BITS    = 96,
    parameter logic [7:0] PREAMBLE_PATTERN = 8'hAA,
    parameter int         LEN_W            = 12
) (
    input logic         clk,
    input logic         rst_n,
    ppdu_framer_if.slave f
);
    localparam int CW = LEN_W + 4;
    localparam logic [3:0] IDLE = 4'd0, PRE = 4'd1, SRATE = 4'd2, SRSVD = 4'd3, SLEN = 4'd4,
                           SPAR = 4'd5, STAIL = 4'd6, SERV = 4'd7, PSDU = 4'd8, DTAIL = 4'd9,
                           PAD = 4'd10;

    logic [3:0]       st, nst, rate_r, sr_cnt;
    logic [LEN_W-1:0] len_r;
    logic [CW-1:0]    cnt, lim;
    logic [7:0]       pc, ndbps, sr, hold;
    logic [LEN_W:0]   fetched;
    logic [11:0]      len12;
    logic [2:0]       field;
    logic             hold_full, fire, last, pcw, take, bit_out, done_r, err_r, ok;

    function automatic logic [7:0] dbps(input logic [3:0] r);
        case (r)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd0;
        endcase
    endfunction

    assign ndbps = dbps(rate_r);
    assign len12 = 12'(len_r);
    assign pcw   = pc == ndbps - 8'd1;
    assign ok    = dbps(f.rate) != 8'd0 && f.length != '0;
    assign fire  = f.bit_valid && f.bit_ready;
    assign take  = f.byte_valid && f.byte_ready;
    assign nst   = (st == PAD || (st == DTAIL && pcw)) ? IDLE : st + 4'd1;

    always_comb begin
        lim = st == PRE ? CW'(PREAMBLE_BITS) : st == SRATE ? CW'(4) : st == SLEN ? CW'(12) :
              (st == STAIL || st == DTAIL) ? CW'(6) : st == SERV ? CW'(16) :
              st == PSDU ? {1'b0, len_r, 3'b000} : CW'(1);
        last = st == PAD ? pcw : cnt == lim - CW'(1);
        field = st == PRE ? 3'd1 : st inside {[SRATE:STAIL]} ? 3'd2 : st == SERV ? 3'd3 :
                st == PSDU ? 3'd4 : st == DTAIL ? 3'd5 : st == PAD ? 3'd6 : 3'd0;
        // Holding register supplies the bit directly whenever the shift register has run dry
        bit_out = st == PRE ? PREAMBLE_PATTERN[3'd7 - cnt[2:0]] :
                  st == SRATE ? rate_r[2'd3 - cnt[1:0]] :
                  st == SLEN ? len12[cnt[3:0]] :
                  st == SPAR ? ^{rate_r, len12} :
                  st == PSDU ? (sr_cnt != 4'd0 ? sr[0] : hold[0]) : 1'b0;
    end

    assign f.bit_out     = bit_out;
    assign f.field       = field;
    assign f.scramble_en = field >= 3'd3;
    assign f.code_en     = field >= 3'd2;
    assign f.seed_load   = st == SERV && cnt == '0;
    assign f.busy        = st != IDLE;
    assign f.bit_valid   = st != IDLE && (st != PSDU || sr_cnt != 4'd0 || hold_full);
    assign f.byte_ready  = (st == SERV || st == PSDU) && !hold_full && fetched < {1'b0, len_r};
    assign f.done        = done_r;
    assign f.error       = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            rate_r <= '0;
            len_r <= '0;
            cnt <= '0;
            pc <= '0;
            sr <= '0;
            sr_cnt <= '0;
            hold <= '0;
            hold_full <= 1'b0;
            fetched <= '0;
            done_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            done_r <= fire && last && nst == IDLE;
            err_r <= st == IDLE && f.start && !ok;
            if (take) begin
                hold <= f.byte_in;
                hold_full <= 1'b1;
                fetched <= fetched + 1'b1;
            end
            if (st == IDLE) begin
                cnt <= '0;
                pc <= '0;
                sr_cnt <= '0;
                hold_full <= 1'b0;
                fetched <= '0;
                if (f.start && ok) begin
                    st <= PRE;
                    rate_r <= f.rate;
                    len_r <= f.length;
                end
            end else if (fire) begin
                st <= last ? nst : st;
                cnt <= last ? '0 : cnt + CW'(1);
                pc <= st < SERV ? 8'd0 : pcw ? 8'd0 : pc + 8'd1;
                if (st == PSDU) begin
                    if (sr_cnt > 4'd1) begin
                        sr <= sr >> 1;
                        sr_cnt <= sr_cnt - 4'd1;
                    end else if (sr_cnt == 4'd1 && !hold_full) begin
                        sr_cnt <= 4'd0;
                    end else begin
                        sr <= sr_cnt == 4'd0 ? hold >> 1 : hold;
                        sr_cnt <= sr_cnt == 4'd0 ? 4'd7 : 4'd8;
                        hold_full <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
